ex_mem_latch: RTL and testbench

EX_MEM_LATCH -- requirements
Module: ex_mem_latch

---
 rtl/ex_mem_latch_pkg.sv | 33 +++
 rtl/ex_mem_latch_if.sv | 54 +++++
 rtl/ex_mem_latch_halt_tracker.sv | 56 +++++
 rtl/ex_mem_latch.sv | 123 ++++++++++++
 tb/tb_ex_mem_latch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_latch_pkg.sv
// Shared EX/MEM pipeline definitions: access-size masks, halt FSM states,
// bubble values and the alignment rule used by the optional misalignment trap.
package ex_mem_latch_pkg;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_SEEN = 2'd1,
    ST_HALTED    = 2'd2
  } halt_state_e;

  typedef struct packed {
    logic valid;
    logic wr_mem;
    logic is_unsigned;
    logic mem_to_reg;
    logic wr_reg;
  } ctrl_t;

  localparam ctrl_t      BUBBLE_CTRL = '0;
  localparam logic [1:0] BUBBLE_MASK = MASK_BYTE;

  // Mask 10 is not a legal size code; it is treated as a word for alignment.
  function automatic logic misaligned_access(input logic [1:0] mask,
                                             input logic [1:0] addr_lo);
    return ((mask == MASK_HALF) && addr_lo[0]) ||
           (mask[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX -> MEM stage bundle: EX-side controls/data in, latched MEM-side copies,
// forwarding path and status out.
interface ex_mem_latch_if #(
  parameter int TAM_DATA     = 32,
  parameter int TAM_MASK     = 2,
  parameter int NUM_REG_BITS = 5
);
  logic                    i_enable;
  logic                    i_stall;
  logic                    i_flush;
  logic                    i_valid;
  logic                    i_halt;
  logic                    i_wr_mem;
  logic                    i_is_unsigned;
  logic                    i_mem_to_reg;
  logic                    i_wr_reg;
  logic [TAM_MASK-1:0]     i_data_mask;
  logic [TAM_DATA-1:0]     i_alu_result;
  logic [TAM_DATA-1:0]     i_store_data;
  logic [NUM_REG_BITS-1:0] i_rd;

  logic                    o_valid;
  logic                    o_wr_mem;
  logic                    o_is_unsigned;
  logic                    o_mem_to_reg;
  logic                    o_wr_reg;
  logic [TAM_MASK-1:0]     o_data_mask;
  logic [TAM_DATA-1:0]     o_direc_mem;
  logic [TAM_DATA-1:0]     o_data;
  logic [NUM_REG_BITS-1:0] o_rd;
  logic                    o_fwd_en;
  logic [TAM_DATA-1:0]     o_fwd_data;
  logic                    o_halted;
  logic [31:0]             o_instr_count;
  logic                    o_misaligned;

  modport slave (
    input  i_enable, i_stall, i_flush, i_valid, i_halt, i_wr_mem,
           i_is_unsigned, i_mem_to_reg, i_wr_reg, i_data_mask,
           i_alu_result, i_store_data, i_rd,
    output o_valid, o_wr_mem, o_is_unsigned, o_mem_to_reg, o_wr_reg,
           o_data_mask, o_direc_mem, o_data, o_rd, o_fwd_en, o_fwd_data,
           o_halted, o_instr_count, o_misaligned
  );

  modport master (
    output i_enable, i_stall, i_flush, i_valid, i_halt, i_wr_mem,
           i_is_unsigned, i_mem_to_reg, i_wr_reg, i_data_mask,
           i_alu_result, i_store_data, i_rd,
    input  o_valid, o_wr_mem, o_is_unsigned, o_mem_to_reg, o_wr_reg,
           o_data_mask, o_direc_mem, o_data, o_rd, o_fwd_en, o_fwd_data,
           o_halted, o_instr_count, o_misaligned
  );
endinterface

// File: rtl/ex_mem_latch_halt_tracker.sv
// Halt FSM (RUN -> HALT_SEEN -> HALTED) plus retired-instruction counter.
// HALTED is sticky until reset; the counter only advances on real loads in RUN.
module halt_tracker
  import ex_mem_latch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic        valid_i,
  input  logic        halt_i,
  input  logic        trap_i,
  output halt_state_e state_o,
  output logic        halted_o,
  output logic        halt_accept_o,
  output logic [31:0] count_o
);

  halt_state_e state_q, state_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      count_q <= '0;
    end else if (enable_i) begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    halt_accept_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_i && valid_i && halt_i) begin
          state_d       = ST_HALT_SEEN;
          halt_accept_o = 1'b1;
        end else if (load_i && valid_i && !trap_i) begin
          count_d = count_q + 32'd1;
        end
      end
      // Any enabled edge retires the HALT, whether it loads, stalls or flushes.
      ST_HALT_SEEN: state_d = ST_HALTED;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_RUN;
    endcase
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALTED);
  assign count_o  = count_q;

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with flush/stall/enable priority, EX forwarding path,
// halt tracking and an optional misalignment trap (EX_MEM_MISALIGN_TRAP_EN).
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int TAM_DATA     = 32,
  parameter int TAM_MASK     = 2,
  parameter int NUM_REG_BITS = 5
) (
  input  logic          i_clock,
  input  logic          i_reset,
  ex_mem_latch_if.slave bus
);

  ctrl_t                   ctrl_q, ctrl_d;
  logic [TAM_MASK-1:0]     mask_q, mask_d;
  logic [TAM_DATA-1:0]     addr_q, addr_d;
  logic [TAM_DATA-1:0]     data_q, data_d;
  logic [NUM_REG_BITS-1:0] rd_q, rd_d;

  halt_state_e state;
  logic        halt_accept;
  logic        load;
  logic        trap;
  logic        take;

  assign load = bus.i_enable & ~bus.i_flush & ~bus.i_stall;

`ifdef EX_MEM_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign trap = bus.i_valid & (bus.i_wr_mem | bus.i_mem_to_reg) &
                misaligned_access(bus.i_data_mask, bus.i_alu_result[1:0]);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      misaligned_q <= 1'b0;
    else if (load && trap)
      misaligned_q <= 1'b1;
  end

  assign bus.o_misaligned = misaligned_q;
`else
  assign trap             = 1'b0;
  assign bus.o_misaligned = 1'b0;
`endif

  // Only a real, aligned, non-HALT instruction in RUN carries its payload.
  assign take = load & bus.i_valid & ~bus.i_halt & ~trap & (state == ST_RUN);

  halt_tracker u_tracker (
    .clk           (i_clock),
    .rst_n         (i_reset),
    .enable_i      (bus.i_enable),
    .load_i        (load),
    .valid_i       (bus.i_valid),
    .halt_i        (bus.i_halt),
    .trap_i        (trap),
    .state_o       (state),
    .halted_o      (bus.o_halted),
    .halt_accept_o (halt_accept),
    .count_o       (bus.o_instr_count)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    addr_d = addr_q;
    data_d = data_q;
    rd_d   = rd_q;
    if (bus.i_enable && (bus.i_flush || !bus.i_stall)) begin
      if (take) begin
        ctrl_d.valid       = 1'b1;
        ctrl_d.wr_mem      = bus.i_wr_mem;
        ctrl_d.is_unsigned = bus.i_is_unsigned;
        ctrl_d.mem_to_reg  = bus.i_mem_to_reg;
        ctrl_d.wr_reg      = bus.i_wr_reg;
        mask_d             = bus.i_data_mask;
        addr_d             = bus.i_alu_result;
        data_d             = bus.i_store_data;
        rd_d               = bus.i_rd;
      end else begin
        // An accepted HALT travels down the pipe as a valid bubble.
        ctrl_d       = BUBBLE_CTRL;
        ctrl_d.valid = halt_accept;
        mask_d       = BUBBLE_MASK;
        addr_d       = '0;
        data_d       = '0;
        rd_d         = '0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q <= BUBBLE_CTRL;
      mask_q <= BUBBLE_MASK;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.o_valid       = ctrl_q.valid;
  assign bus.o_wr_mem      = ctrl_q.wr_mem;
  assign bus.o_is_unsigned = ctrl_q.is_unsigned;
  assign bus.o_mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.o_wr_reg      = ctrl_q.wr_reg;
  assign bus.o_data_mask   = mask_q;
  assign bus.o_direc_mem   = addr_q;
  assign bus.o_data        = data_q;
  assign bus.o_rd          = rd_q;
  assign bus.o_fwd_en      = ctrl_q.valid & ctrl_q.wr_reg & ~ctrl_q.mem_to_reg &
                             (rd_q != '0);
  assign bus.o_fwd_data    = addr_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed + randomized bench for ex_mem_latch against a behavioural model of
// the latch priority, halt sequence, counter and optional misalignment trap.
module tb_ex_mem_latch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_latch_if bus ();
  ex_mem_latch dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected MEM-stage contents; phase: 0 running, 1 HALT just latched, 2 halted.
  bit          e_valid, e_wr_mem, e_uns, e_m2r, e_wr_reg;
  bit [1:0]    e_mask;
  bit [31:0]   e_addr, e_data;
  bit [4:0]    e_rd;
  bit [31:0]   e_count;
  int          e_phase;
  bit          e_mis;
  bit [31:0]   snap_addr, snap_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    e_valid = 0; e_wr_mem = 0; e_uns = 0; e_m2r = 0; e_wr_reg = 0;
    e_mask = 2'b00; e_addr = 0; e_data = 0; e_rd = 0;
  endtask

  task automatic model_reset();
    model_bubble();
    e_count = 0; e_phase = 0; e_mis = 0;
  endtask

  // Applies the inputs currently on the bus to the model, as one rising edge.
  task automatic model_edge();
    bit ld;
    bit mis;
    if (!bus.i_enable) return;
    ld  = !bus.i_flush && !bus.i_stall;
    mis = 0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    if (bus.i_valid && (bus.i_wr_mem || bus.i_mem_to_reg)) begin
      if (bus.i_data_mask == 2'b01) mis = bus.i_alu_result[0];
      else if (bus.i_data_mask[1]) mis = (bus.i_alu_result[1:0] != 2'b00);
    end
    if (ld && mis) e_mis = 1;
`endif
    if (bus.i_flush) model_bubble();
    else if (ld) begin
      if (e_phase != 0 || !bus.i_valid) model_bubble();
      else if (bus.i_halt) begin model_bubble(); e_valid = 1; end
      else if (mis) model_bubble();
      else begin
        e_valid = 1; e_wr_mem = bus.i_wr_mem; e_uns = bus.i_is_unsigned;
        e_m2r = bus.i_mem_to_reg; e_wr_reg = bus.i_wr_reg; e_mask = bus.i_data_mask;
        e_addr = bus.i_alu_result; e_data = bus.i_store_data; e_rd = bus.i_rd;
        e_count = e_count + 1;
      end
    end
    if (e_phase == 1) e_phase = 2;
    else if (e_phase == 0 && ld && bus.i_valid && bus.i_halt) e_phase = 1;
  endtask

  task automatic check_all(input string tag);
    bit fwd;
    fwd = e_valid && e_wr_reg && !e_m2r && (e_rd != 0);
    chk({tag, "/valid"},  32'(bus.o_valid),       32'(e_valid));
    chk({tag, "/wr_mem"}, 32'(bus.o_wr_mem),      32'(e_wr_mem));
    chk({tag, "/uns"},    32'(bus.o_is_unsigned), 32'(e_uns));
    chk({tag, "/m2r"},    32'(bus.o_mem_to_reg),  32'(e_m2r));
    chk({tag, "/wr_reg"}, 32'(bus.o_wr_reg),      32'(e_wr_reg));
    chk({tag, "/mask"},   32'(bus.o_data_mask),   32'(e_mask));
    chk({tag, "/addr"},   bus.o_direc_mem,        e_addr);
    chk({tag, "/data"},   bus.o_data,             e_data);
    chk({tag, "/rd"},     32'(bus.o_rd),          32'(e_rd));
    chk({tag, "/fwd_en"}, 32'(bus.o_fwd_en),      32'(fwd));
    chk({tag, "/fwd_d"},  bus.o_fwd_data,         e_addr);
    chk({tag, "/halted"}, 32'(bus.o_halted),      32'(e_phase == 2));
    chk({tag, "/count"},  bus.o_instr_count,      e_count);
    chk({tag, "/mis"},    32'(bus.o_misaligned),  32'(e_mis));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic ctl(input bit en, input bit fl, input bit st);
    bus.i_enable = en; bus.i_flush = fl; bus.i_stall = st;
  endtask

  task automatic set_in(input bit v, input bit h, input bit wm, input bit us,
                        input bit mr, input bit wr, input bit [1:0] mk,
                        input bit [31:0] ad, input bit [31:0] dt, input bit [4:0] rd);
    bus.i_valid = v; bus.i_halt = h; bus.i_wr_mem = wm; bus.i_is_unsigned = us;
    bus.i_mem_to_reg = mr; bus.i_wr_reg = wr; bus.i_data_mask = mk;
    bus.i_alu_result = ad; bus.i_store_data = dt; bus.i_rd = rd;
  endtask

  task automatic rnd_in();
    set_in($urandom_range(0, 3) != 0, 1'b0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
           $urandom, $urandom, 5'($urandom));
  endtask

  // Asynchronous reset in the middle of a cycle, released on a later edge.
  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(posedge clk);
    #1 check_all({tag, "_edge"});
    rst_n = 1'b1;
  endtask

  initial begin
    ctl(1'b0, 1'b0, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    model_reset();
    #3 check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    ctl(1'b1, 1'b0, 1'b0);

    // Store word at 0x10.
    set_in(1, 0, 1, 0, 0, 0, 2'b11, 32'h10, 32'hAABB_CCDD, 5'd0);
    step("store");
    chk("store_addr", bus.o_direc_mem, 32'h10);
    chk("store_data", bus.o_data, 32'hAABB_CCDD);
    chk("store_cnt", bus.o_instr_count, 32'd1);

    // Forwarding of an ALU result, then the same op targeting r0.
    set_in(1, 0, 0, 0, 0, 1, 2'b11, 32'h1234, 32'h0, 5'd5);
    step("alu_rd5");
    chk("fwd_en_rd5", 32'(bus.o_fwd_en), 32'd1);
    chk("fwd_data_rd5", bus.o_fwd_data, 32'h1234);
    set_in(1, 0, 0, 0, 0, 1, 2'b11, 32'h1234, 32'h0, 5'd0);
    step("alu_rd0");
    chk("fwd_en_rd0", 32'(bus.o_fwd_en), 32'd0);

    // Flush wins over stall; then stall alone holds for three cycles.
    ctl(1'b1, 1'b1, 1'b1);
    set_in(1, 0, 0, 0, 0, 1, 2'b01, 32'h40, 32'h55, 5'd7);
    step("flush_stall");
    chk("flush_cnt", bus.o_instr_count, 32'd3);
    ctl(1'b1, 1'b0, 1'b0);
    set_in(1, 0, 0, 1, 1, 1, 2'b01, 32'h80, 32'h99, 5'd9);
    step("pre_stall");
    snap_addr = bus.o_direc_mem;
    snap_data = bus.o_data;
    ctl(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      step("stall");
      chk("stall_addr", bus.o_direc_mem, snap_addr);
      chk("stall_data", bus.o_data, snap_data);
    end

    // Disabled edges hold everything, even with flush asserted.
    ctl(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rnd_in();
      step("disabled");
    end

    // Reset mid-stall discards held contents.
    ctl(1'b1, 1'b0, 1'b1);
    async_reset("rst_stall");
    ctl(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ctl($urandom_range(0, 15) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      rnd_in();
      step("rnd");
    end

    // Counter wrap: preset the count to all-ones while the latch is frozen.
    ctl(1'b0, 1'b0, 1'b0);
    force dut.u_tracker.count_q = 32'hFFFF_FFFF;
    #2 release dut.u_tracker.count_q;
    e_count = 32'hFFFF_FFFF;
    #1 chk("preset_cnt", bus.o_instr_count, 32'hFFFF_FFFF);
    ctl(1'b1, 1'b0, 1'b0);
    set_in(1, 0, 0, 0, 0, 1, 2'b11, 32'h0, 32'h0, 5'd3);
    step("wrap");
    chk("wrap_cnt", bus.o_instr_count, 32'd0);
    step("post_wrap");

    // HALT then two valid instructions.
    set_in(1, 1, 0, 0, 0, 0, 2'b11, 32'h44, 32'h0, 5'd0);
    step("halt");
    chk("halt_valid", 32'(bus.o_valid), 32'd1);
    chk("halt_not_yet", 32'(bus.o_halted), 32'd0);
    set_in(1, 0, 0, 0, 0, 1, 2'b11, 32'h48, 32'h1, 5'd4);
    step("after_halt1");
    chk("halted_now", 32'(bus.o_halted), 32'd1);
    set_in(1, 0, 1, 0, 0, 1, 2'b11, 32'h4C, 32'h2, 5'd6);
    step("after_halt2");
    chk("halt_cnt_frozen", bus.o_instr_count, 32'd1);
    async_reset("rst_halted");

    // Stall, flush and disable while in HALT_SEEN.
    set_in(1, 1, 0, 0, 0, 0, 2'b11, 32'h0, 32'h0, 5'd0);
    step("halt_b");
    ctl(1'b1, 1'b0, 1'b1);
    step("halt_stall");
    chk("halt_stall_halted", 32'(bus.o_halted), 32'd1);
    ctl(1'b1, 1'b0, 1'b0);
    async_reset("rst_b");
    step("halt_c");
    ctl(1'b1, 1'b1, 1'b0);
    step("halt_flush");
    ctl(1'b0, 1'b0, 1'b0);
    async_reset("rst_c");
    ctl(1'b1, 1'b0, 1'b0);
    step("halt_d");
    ctl(1'b0, 1'b0, 1'b0);
    step("halt_disabled");
    chk("halt_disabled_not", 32'(bus.o_halted), 32'd0);
    ctl(1'b1, 1'b0, 1'b0);
    step("halt_enabled");
    async_reset("rst_d");

    // Word access at 0x2, then a half store at 0x2.
    set_in(1, 0, 0, 0, 1, 1, 2'b11, 32'h2, 32'h0, 5'd8);
    step("word_at_2");
`ifdef EX_MEM_MISALIGN_TRAP_EN
    chk("trap_bubble", 32'(bus.o_valid), 32'd0);
    chk("trap_flag", 32'(bus.o_misaligned), 32'd1);
`else
    chk("pass_word", 32'(bus.o_valid), 32'd1);
    chk("no_flag", 32'(bus.o_misaligned), 32'd0);
`endif
    set_in(1, 0, 1, 0, 0, 0, 2'b01, 32'h2, 32'hBEEF, 5'd0);
    step("half_at_2");
    chk("half_pass", bus.o_direc_mem, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
